// File: rtl/da_ctrl_if.sv
// Handshake bundle between the host and da_ctrl: coefficient stream,
// sample-frame stream and result return, each valid/ready.
interface da_ctrl_if #(
   parameter int CW   = 20,
   parameter int AXW  = 8,
   parameter int ACCW = 38
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CW-1:0]     cfg_data;
   logic              smp_valid;
   logic              smp_ready;
   logic [8*AXW-1:0]  smp_data;
   logic              res_valid;
   logic              res_ready;
   logic [ACCW-1:0]   res_data;

   modport master (
      output cfg_valid, cfg_data, input cfg_ready,
      output smp_valid, smp_data, input smp_ready,
      input  res_valid, res_data, output res_ready
   );

   modport slave (
      input  cfg_valid, cfg_data, output cfg_ready,
      input  smp_valid, smp_data, output smp_ready,
      output res_valid, res_data, input res_ready
   );
endinterface

// File: rtl/da_ctrl.sv
// da_ctrl: sequencer in front of the distributed-arithmetic FIR datapath.
// Streams the coefficient ROM image into da, then issues one start per
// sample frame and returns the captured accumulator on the result port.
// Optional done-timeout (sticky err, zero result) with DA_CTRL_TIMEOUT_EN.
module da_ctrl #(
   parameter int CW   = 20,
   parameter int AW   = 11,
   parameter int AXW  = 8,
   parameter int ACCW = 38
`ifdef DA_CTRL_TIMEOUT_EN
   ,
   parameter int TMO  = 64
`endif
) (
   input  logic              clk,
   input  logic              resetn,
   da_ctrl_if.slave          bus,
   input  logic              reload,
   output logic              loaded,
   output logic [AW-1:0]     da_caddr,
   output logic [CW-1:0]     da_cin,
   output logic              da_cload,
   output logic              da_valid_in,
   output logic [8*AXW-1:0]  da_a,
   output logic              da_start,
   input  logic              da_done,
   input  logic [ACCW-1:0]   da_acc,
   output logic              err
);

   typedef enum logic [1:0] {LOAD, READY, BUSY} state_t;

   localparam logic [AW:0] LAST = (AW+1)'((1 << AW) - 1);

   state_t      state, state_nxt;
   logic [AW:0] cnt;
   logic        reload_pend;
   logic        beat_acc, smp_acc, capture, timeout;

`ifdef DA_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   assign tmo_hit = (tmo_cnt == TW'(TMO - 1));
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= LOAD;
      else         state <= state_nxt;
   end

   // Next state, ready outputs and per-cycle accept/capture strobes
   always_comb begin
      state_nxt     = state;
      bus.cfg_ready = 1'b0;
      bus.smp_ready = 1'b0;
      beat_acc      = 1'b0;
      smp_acc       = 1'b0;
      capture       = 1'b0;
      timeout       = 1'b0;
      unique case (state)
         LOAD: begin
            bus.cfg_ready = 1'b1;
            // a beat coinciding with reload is dropped so the image restarts at 0
            beat_acc = bus.cfg_valid && !reload;
            if (beat_acc && cnt == LAST) state_nxt = READY;
         end
         READY: begin
            // reload wins over a frame offered in the same cycle
            bus.smp_ready = !reload && (!bus.res_valid || bus.res_ready);
            if (reload) begin
               state_nxt = LOAD;
            end else if (bus.smp_valid && bus.smp_ready) begin
               smp_acc   = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            // done in the start cycle belongs to a previous run; ignore it
            capture = da_done && !da_start;
`ifdef DA_CTRL_TIMEOUT_EN
            timeout = tmo_hit && !capture;
`endif
            if (capture || timeout)
               state_nxt = (reload || reload_pend) ? LOAD : READY;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Coefficient load path, frame issue, result capture and reload bookkeeping
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt           <= '0;
         loaded        <= 1'b0;
         da_caddr      <= '0;
         da_cin        <= '0;
         da_cload      <= 1'b0;
         da_valid_in   <= 1'b0;
         da_a          <= '0;
         da_start      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         reload_pend   <= 1'b0;
      end else begin
         da_cload    <= beat_acc;
         da_valid_in <= beat_acc;
         da_start    <= smp_acc;
         if (beat_acc) begin
            da_caddr <= cnt[AW-1:0];
            da_cin   <= bus.cfg_data;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST) loaded <= 1'b1;
         end
         if (smp_acc) da_a <= bus.smp_data;
         if (capture || timeout) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= capture ? da_acc : '0;
         end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
         end
         if (reload && state != BUSY) begin
            cnt    <= '0;
            loaded <= 1'b0;
         end
         if (reload && state == BUSY) reload_pend <= 1'b1;
         // deferred reload takes effect once the in-flight result is captured
         if (state == BUSY && state_nxt == LOAD) begin
            cnt         <= '0;
            loaded      <= 1'b0;
            reload_pend <= 1'b0;
         end
      end
   end

`ifdef DA_CTRL_TIMEOUT_EN
   // BUSY cycle counter, restarted whenever a frame is issued
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)             tmo_cnt <= '0;
      else if (smp_acc)        tmo_cnt <= '0;
      else if (state == BUSY)  tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Sticky timeout flag, cleared by a reload taking effect
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                     err <= 1'b0;
      else if (reload && state != BUSY) err <= 1'b0;
      else if (timeout)                err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_da_ctrl.sv
// Self-checking bench for da_ctrl. A behavioural da responder answers each
// start with done after a fixed latency; expectations come from the
// load/frame/result rules computed directly in each test task.
module tb_da_ctrl;
   localparam int CW = 20, AW = 11, AXW = 8, ACCW = 38;
   localparam int N = 2048, LAT = 9, TMO = 64;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              reload = 1'b0;
   logic              loaded, da_cload, da_valid_in, da_start, err;
   logic [AW-1:0]     da_caddr;
   logic [CW-1:0]     da_cin;
   logic [8*AXW-1:0]  da_a;
   logic              da_done;
   logic [ACCW-1:0]   da_acc;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   da_ctrl_if #(.CW(CW), .AXW(AXW), .ACCW(ACCW)) bus ();

   da_ctrl #(.CW(CW), .AW(AW), .AXW(AXW), .ACCW(ACCW)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .reload(reload), .loaded(loaded),
      .da_caddr(da_caddr), .da_cin(da_cin), .da_cload(da_cload),
      .da_valid_in(da_valid_in), .da_a(da_a), .da_start(da_start),
      .da_done(da_done), .da_acc(da_acc), .err(err)
   );

   always #5 clk = ~clk;

   // behavioural da: done pulse LAT cycles after start, or manual drive
   bit              rsp_en = 1'b1;
   logic            rsp_done = 1'b0;
   logic [ACCW-1:0] rsp_acc = '0;
   int              rsp_cd = 0;
   logic            man_done = 1'b0;
   logic [ACCW-1:0] man_acc = '0;

   assign da_done = rsp_done | man_done;
   assign da_acc  = rsp_done ? rsp_acc : man_acc;

   always @(negedge clk) begin
      rsp_done = 1'b0;
      if (rsp_cd > 0) begin
         rsp_cd = rsp_cd - 1;
         if (rsp_cd == 0) rsp_done = 1'b1;
      end
      if (da_start && rsp_en) rsp_cd = LAT;
   end

   task automatic test_reset();
      resetn = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_data = '0;
      bus.smp_valid = 1'b0; bus.smp_data = '0; bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({da_cload, da_valid_in, da_start, loaded, err, bus.res_valid} !== 6'b0) begin n_bad++; $display("FAIL rst_flags got %b want 000000", {da_cload, da_valid_in, da_start, loaded, err, bus.res_valid}); end
      n_cmp++; if (da_caddr !== '0 || da_cin !== '0 || da_a !== '0 || bus.res_data !== '0) begin n_bad++; $display("FAIL rst_data got caddr=%0h cin=%0h a=%0h res=%0h want 0", da_caddr, da_cin, da_a, bus.res_data); end
      resetn = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cfg_ready got %b want 1", bus.cfg_ready); end
      n_cmp++; if (bus.smp_ready !== 1'b0) begin n_bad++; $display("FAIL rst_smp_ready got %b want 0", bus.smp_ready); end
   endtask

   // mode 0: valid held, data=index; 1: valid toggles; 2: random valid/data
   task automatic test_load(input int mode, input string tag);
      int unsigned nacc, nchk, cyc, first, last;
      bit pend, v;
      logic [CW-1:0] pdata;
      nacc = 0; nchk = 0; cyc = 0; first = 0; last = 0; pend = 0; pdata = '0;
      while (nchk < N) begin
         @(negedge clk);
         if (cyc > 3*N + 100) begin
            n_cmp++; n_bad++; $display("FAIL %s_timeout got %0d beats want %0d", tag, nchk, N);
            break;
         end
         if (pend) begin
            n_cmp++; if (da_cload !== 1'b1 || da_valid_in !== 1'b1) begin n_bad++; $display("FAIL %s_cload got %b%b want 11 at beat %0d", tag, da_cload, da_valid_in, nchk); end
            n_cmp++; if (da_caddr !== AW'(nchk) || da_cin !== pdata) begin n_bad++; $display("FAIL %s_beat got addr=%0d cin=%0h want addr=%0d cin=%0h", tag, da_caddr, da_cin, nchk, pdata); end
            nchk++;
            n_cmp++; if (loaded !== (nchk == N)) begin n_bad++; $display("FAIL %s_loaded got %b want %b at beat %0d", tag, loaded, nchk == N, nchk); end
         end else begin
            n_cmp++; if (da_cload !== 1'b0) begin n_bad++; $display("FAIL %s_idle_cload got %b want 0", tag, da_cload); end
         end
         if (nchk == N) break;
         n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL %s_cfg_ready got %b want 1", tag, bus.cfg_ready); end
         v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
         bus.cfg_valid = v;
         bus.cfg_data  = (mode == 0) ? CW'(nacc) : CW'($urandom);
         pend  = v;
         pdata = bus.cfg_data;
         if (v) begin
            if (nacc == 0) first = cyc;
            last = cyc;
            nacc++;
         end
         cyc++;
      end
      if (mode < 2) begin
         n_cmp++; if (last - first + 1 != ((mode == 0) ? N : 2*N - 1)) begin n_bad++; $display("FAIL %s_span got %0d want %0d", tag, last - first + 1, (mode == 0) ? N : 2*N - 1); end
      end
      bus.cfg_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_cmp++; if (bus.cfg_ready !== 1'b0 || da_cload !== 1'b0 || loaded !== 1'b1) begin n_bad++; $display("FAIL %s_extra got ready=%b cload=%b loaded=%b want 0 0 1", tag, bus.cfg_ready, da_cload, loaded); end
      end
      bus.cfg_valid = 1'b0;
   endtask

   task automatic test_frame(input logic [63:0] frame, input logic [ACCW-1:0] acc, input bit consume, input string tag);
      int unsigned w, starts;
      rsp_acc = acc;
      bus.res_ready = 1'b0;
      n_cmp++; if (bus.smp_ready !== 1'b1) begin n_bad++; $display("FAIL %s_smp_ready got %b want 1", tag, bus.smp_ready); end
      bus.smp_valid = 1'b1; bus.smp_data = frame;
      @(negedge clk);
      bus.smp_valid = 1'b0;
      n_cmp++; if (da_start !== 1'b1 || da_a !== frame) begin n_bad++; $display("FAIL %s_start got start=%b a=%0h want 1 %0h", tag, da_start, da_a, frame); end
      n_cmp++; if (bus.smp_ready !== 1'b0) begin n_bad++; $display("FAIL %s_busy_ready got %b want 0", tag, bus.smp_ready); end
      w = 0; starts = 0;
      do begin
         @(negedge clk); w++;
         if (da_start) starts++;
      end while (bus.res_valid !== 1'b1 && w < 200);
      n_cmp++; if (w != LAT + 1 || starts != 0) begin n_bad++; $display("FAIL %s_latency got %0d cycles %0d starts want %0d cycles 0 starts", tag, w, starts, LAT + 1); end
      n_cmp++; if (bus.res_data !== acc) begin n_bad++; $display("FAIL %s_res_data got %0h want %0h", tag, bus.res_data, acc); end
      n_cmp++; if (da_a !== frame) begin n_bad++; $display("FAIL %s_a_hold got %0h want %0h", tag, da_a, frame); end
      if (consume) begin
         bus.res_ready = 1'b1;
         @(negedge clk);
         bus.res_ready = 1'b0;
         n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL %s_consume got %b want 0", tag, bus.res_valid); end
      end
   endtask

   task automatic test_back_to_back();
      logic [ACCW-1:0] keep, acc2;
      logic [63:0] f2;
      int unsigned w;
      test_frame(64'h0706050403020100, 38'd12345, 1'b0, "bp_first");
      keep = bus.res_data;
      f2   = {$urandom, $urandom};
      acc2 = ACCW'({$urandom, $urandom});
      rsp_acc = acc2;
      bus.smp_valid = 1'b1; bus.smp_data = f2;
      repeat (4) begin
         @(negedge clk);
         n_cmp++; if (bus.smp_ready !== 1'b0 || da_start !== 1'b0) begin n_bad++; $display("FAIL bp_stall got ready=%b start=%b want 0 0", bus.smp_ready, da_start); end
         n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== keep) begin n_bad++; $display("FAIL bp_hold got v=%b d=%0h want 1 %0h", bus.res_valid, bus.res_data, keep); end
      end
      bus.res_ready = 1'b1;
      #1;
      n_cmp++; if (bus.smp_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b want 1", bus.smp_ready); end
      @(negedge clk);
      bus.res_ready = 1'b0; bus.smp_valid = 1'b0;
      n_cmp++; if (da_start !== 1'b1 || da_a !== f2 || bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept got start=%b a=%0h v=%b want 1 %0h 0", da_start, da_a, bus.res_valid, f2); end
      w = 0;
      do begin @(negedge clk); w++; end while (bus.res_valid !== 1'b1 && w < 200);
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== acc2) begin n_bad++; $display("FAIL bp_second got v=%b d=%0h want 1 %0h", bus.res_valid, bus.res_data, acc2); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reload_busy();
      logic [ACCW-1:0] acc;
      int unsigned w;
      acc = ACCW'({$urandom, $urandom});
      rsp_acc = acc;
      bus.smp_valid = 1'b1; bus.smp_data = {$urandom, $urandom};
      @(negedge clk);
      bus.smp_valid = 1'b0;
      n_cmp++; if (da_start !== 1'b1) begin n_bad++; $display("FAIL rl_start got %b want 1", da_start); end
      repeat (3) @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      w = 4;
      while (bus.res_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== acc) begin n_bad++; $display("FAIL rl_capture got v=%b d=%0h want 1 %0h", bus.res_valid, bus.res_data, acc); end
      n_cmp++; if (loaded !== 1'b0 || bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rl_to_load got loaded=%b cfg_ready=%b want 0 1", loaded, bus.cfg_ready); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      test_load(1, "load_toggle");
   endtask

   task automatic test_reset_mid();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      n_cmp++; if (bus.cfg_ready !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL rm_reload got ready=%b loaded=%b want 1 0", bus.cfg_ready, loaded); end
      bus.cfg_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         bus.cfg_data = CW'($urandom);
         @(negedge clk);
      end
      n_cmp++; if (da_caddr !== AW'(999)) begin n_bad++; $display("FAIL rm_progress got %0d want 999", da_caddr); end
      resetn = 1'b0;
      #1;
      n_cmp++; if ({da_cload, da_valid_in, da_start, loaded, err, bus.res_valid} !== 6'b0 || da_caddr !== '0 || da_cin !== '0 || da_a !== '0) begin n_bad++; $display("FAIL rm_abort got flags=%b caddr=%0h cin=%0h a=%0h want 0", {da_cload, da_valid_in, da_start, loaded, err, bus.res_valid}, da_caddr, da_cin, da_a); end
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      test_load(2, "load_random");
   endtask

`ifdef DA_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      rsp_en = 1'b0;
      bus.smp_valid = 1'b1; bus.smp_data = {$urandom, $urandom};
      @(negedge clk);
      bus.smp_valid = 1'b0;
      n_cmp++; if (da_start !== 1'b1) begin n_bad++; $display("FAIL to_start got %b want 1", da_start); end
      repeat (TMO - 1) @(negedge clk);
      n_cmp++; if (err !== 1'b0 || bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL to_early got err=%b v=%b want 0 0", err, bus.res_valid); end
      @(negedge clk);
      n_cmp++; if (err !== 1'b1 || bus.res_valid !== 1'b1 || bus.res_data !== '0) begin n_bad++; $display("FAIL to_fire got err=%b v=%b d=%0h want 1 1 0", err, bus.res_valid, bus.res_data); end
      man_acc = ACCW'(38'h1234567); man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.res_data !== '0 || err !== 1'b1) begin n_bad++; $display("FAIL to_late_done got d=%0h err=%b want 0 1", bus.res_data, err); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      n_cmp++; if (bus.res_valid !== 1'b0 || bus.smp_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready got v=%b smp_ready=%b want 0 1", bus.res_valid, bus.smp_ready); end
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      n_cmp++; if (err !== 1'b0 || loaded !== 1'b0 || bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL to_reload got err=%b loaded=%b ready=%b want 0 0 1", err, loaded, bus.cfg_ready); end
      rsp_en = 1'b1;
   endtask
`else
   task automatic test_no_timeout();
      logic [ACCW-1:0] acc;
      acc = ACCW'({$urandom, $urandom});
      rsp_en = 1'b0;
      bus.smp_valid = 1'b1; bus.smp_data = {$urandom, $urandom};
      @(negedge clk);
      bus.smp_valid = 1'b0;
      man_acc = ~acc; man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL nt_done_with_start got %b want 0", bus.res_valid); end
      repeat (100) @(negedge clk);
      n_cmp++; if (err !== 1'b0 || bus.res_valid !== 1'b0 || bus.smp_ready !== 1'b0) begin n_bad++; $display("FAIL nt_wait got err=%b v=%b smp_ready=%b want 0 0 0", err, bus.res_valid, bus.smp_ready); end
      man_acc = acc; man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== acc || err !== 1'b0) begin n_bad++; $display("FAIL nt_capture got v=%b d=%0h err=%b want 1 %0h 0", bus.res_valid, bus.res_data, err, acc); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      rsp_en = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_load(0, "load_hold");
      test_frame(64'h0706050403020100, 38'd12345, 1'b1, "frame");
      test_back_to_back();
      for (int i = 0; i < 6; i++)
         test_frame({$urandom, $urandom}, ACCW'({$urandom, $urandom}), 1'b1, "rand_frame");
      test_reload_busy();
      test_reset_mid();
`ifdef DA_CTRL_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/da_ctrl.md
Name: da_ctrl

Overview:
- Sequencer in front of the distributed-arithmetic FIR datapath (`da`). Its clock and reset share the datapath's clk/resetn; the datapath's sclk is driven externally.
- Streams the 8x256 coefficient ROM image into `da` through valid/ready, auto-incrementing the ROM address.
- Then accepts packed sample-address frames, issues one `start` per frame, waits for `done`, and returns the captured ACC through a valid/ready result port.

Parameters:
- CW, 20: coefficient width (da CIN).
- AW, 11: ROM address width (da CADDR); ROM_ENTRIES = 2**AW = 2048.
- AXW, 8: per-tap address width (A0..A7).
- ACCW, 38: accumulator width (da ACC).
- TMO, 64: done-timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  coefficient beat valid.
- cfg_ready  out  1  coefficient beat accepted.
- cfg_data  in  CW  coefficient value.
- reload  in  1  request a fresh ROM load.
- loaded  out  1  full ROM image written.
- smp_valid  in  1  sample frame valid.
- smp_ready  out  1  sample frame accepted.
- smp_data  in  8*AXW  {A7,A6,...,A0}, A0 in LSBs.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_data  out  ACCW  captured ACC.
- da_caddr  out  AW  to da CADDR.
- da_cin  out  CW  to da CIN.
- da_cload  out  1  to da CLOAD.
- da_valid_in  out  1  to da valid_in.
- da_a  out  8*AXW  to da A7..A0.
- da_start  out  1  to da start.
- da_done  in  1  from da done.
- da_acc  in  ACCW  from da ACC.
- err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values: all outputs 0 and state LOAD with load counter cnt=0. Consequently cfg_ready=1 in the first cycle after reset release.
- States are LOAD, READY, BUSY.

LOAD:
- cfg_ready=1, smp_ready=0.
- A beat is accepted when cfg_valid&&cfg_ready. The next cycle drives da_caddr=cnt, da_cin=cfg_data, da_cload=da_valid_in=1, and cnt increments.
- Latency is 1 cycle. Without an accept in a cycle, da_cload=da_valid_in=0 the next cycle and da_caddr/da_cin hold their values.
- On accepting beat cnt=ROM_ENTRIES-1, cfg_ready drops in the same registered update. State goes to READY and loaded=1 in the cycle in which the last da_cload is driven.
- cnt is AW+1 bits. There is no wrap; extra cfg beats are not accepted.

READY:
- smp_ready = !res_valid || res_ready.
- On accept: da_a<=smp_data and da_start=1 for exactly one cycle (next cycle); state goes to BUSY.
- da_a holds its value until the next accept.

BUSY:
- smp_ready=0.
- On da_done: res_data<=da_acc, res_valid<=1, state goes to READY.
- da_done outside BUSY is ignored. So is da_done in the same cycle as da_start (the earliest capture is the cycle after da_start).

Result port:
- res_valid clears on res_ready, unless a new capture happens in the same cycle, in which case it stays 1 with the new data.
- res_data is stable while res_valid && !res_ready.

reload:
- In READY: go to LOAD next cycle; cnt=0, loaded=0, err=0. A pending res_valid is kept.
- In BUSY: latch a pending flag. Finish the current capture, then enter LOAD.
- In LOAD: restart cnt=0. A beat accepted in the same cycle is discarded.
- reload takes priority over smp accept in the same cycle.
- Reset asserted mid-operation (any state) aborts immediately to the reset values; the ROM must then be reloaded.

Optional Feature:
- Macro: DA_CTRL_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in BUSY and clears on entering BUSY.
  - If TMO cycles elapse without da_done: err<=1 (sticky), res_data<=0, res_valid<=1, state goes to READY.
  - A da_done arriving after the timeout is ignored.
  - err is cleared only by reset or reload.
- Without the macro: BUSY waits indefinitely, err is tied 0, and no counter logic is present.

Test Plan:
1. Reset, then stream cfg_data=i for i=0..2047 with cfg_valid held 1. Expect: da_cload high for 2048 consecutive cycles with da_caddr=da_cin=i. loaded rises with the last beat (address 2047). cfg_ready is 0 thereafter.
2. Toggle cfg_valid 1/0 every cycle. Expect: da_cload only on cycles following accepts, addresses contiguous 0..2047 with no gaps or repeats, 4095 cycles total.
3. After load, offer smp_data=64'h0706050403020100. The da model asserts done 9 cycles after start with acc=38'd12345. Expect: one da_start pulse, da_a equal to the frame, res_valid=1, res_data=12345.
4. Hold res_ready=0 with a result pending and offer a second frame. Expect: smp_ready=0 and no da_start. Pulse res_ready: the frame is accepted that cycle and start follows.
5. Assert reload 3 cycles after da_start. Expect: the result is still captured on done, then loaded=0 and da_caddr restarts at 0. Separately, assert resetn=0 at load beat 1000: all outputs go to 0 and cnt restarts at 0.
6. DA_CTRL_TIMEOUT_EN, da_done never asserted. Expect: after 64 BUSY cycles, err=1, res_valid=1 with res_data=0, and state READY. A late da_done is ignored; reload clears err.
